// File: rtl/vector_decode_stage.sv
// Decode stage of a small vector core: control decode, scalar/vector register read and one ID/EX register.
// Define DECODE_WB_BYPASS_EN to forward same-cycle writeback data instead of stalling on it.
module vector_decode_stage #(
    parameter  int LANES  = 4,
    parameter  int LANE_W = 32,
    parameter  int NREGS  = 16,
    localparam int VW     = LANES * LANE_W,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [1:0]        in_inst,
    input  logic              in_flag_v,
    input  logic [26:0]       in_imm,
    input  logic [31:0]       in_pc,
    input  logic [AW-1:0]     in_rd,
    input  logic [AW-1:0]     in_rs1,
    input  logic [AW-1:0]     in_rs2,
    input  logic              wb_en,
    input  logic              wb_vec,
    input  logic [AW-1:0]     wb_addr,
    input  logic [VW-1:0]     wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [VW-1:0]     out_a,
    output logic [VW-1:0]     out_b,
    output logic [AW-1:0]     out_rd,
    output logic [AW-1:0]     out_rs1,
    output logic [AW-1:0]     out_rs2,
    output logic              out_vf,
    output logic              out_wmem,
    output logic              out_rmem,
    output logic              out_wreg,
    output logic              out_cond_en,
    output logic [1:0]        out_jmp,
    output logic [2:0]        out_alu,
    output logic [15:0]       stall_cnt
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // the producer keeps its payload stable while valid && !ready.
    typedef struct packed {
        logic [VW-1:0] a;
        logic [VW-1:0] b;
        logic [AW-1:0] rd;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic          vf;
        logic          wmem;
        logic          rmem;
        logic          wreg;
        logic          cond_en;
        logic [1:0]    jmp;
        logic [2:0]    alu;
    } id_ex_t;

    logic [LANE_W-1:0] scal_q [NREGS];
    logic [LANE_W-1:0] scal_d [NREGS];
    logic [VW-1:0]     vec_q  [NREGS];
    logic [VW-1:0]     vec_d  [NREGS];

    id_ex_t      r_q, r_d, r_new;
    logic        out_valid_q, out_valid_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic        dec_vf, dec_wmem, dec_rmem, dec_wreg, dec_cond_en, dec_jsel;
    logic [1:0]  dec_jmp, dec_ext, dec_mux_r;
    logic [2:0]  dec_alu;
    logic [31:0] ext_val;

    logic [LANE_W-1:0] rs1_s, rs2_s;
    logic [VW-1:0]     rs1_v, rs2_v;
    logic [VW-1:0]     op_a, op_b;

    logic rs1_used, rs2_used, load_use, wb_hazard, hazard, accept;

    // ControlUnit truth table
    always_comb begin
        dec_vf      = 1'b0;
        dec_wmem    = 1'b0;
        dec_rmem    = 1'b0;
        dec_wreg    = 1'b0;
        dec_cond_en = 1'b0;
        dec_jmp     = 2'b00;
        dec_alu     = 3'b000;
        dec_jsel    = 1'b0;
        dec_ext     = 2'b00;
        case (in_op)
            2'b00: begin
                dec_vf   = in_flag_v;
                dec_wreg = 1'b1;
                dec_alu  = {1'b0, in_inst};
            end
            2'b01: begin
                dec_vf   = in_flag_v;
                dec_wreg = 1'b1;
                if (in_inst == 2'b11) begin
                    dec_alu = 3'b100;
                    dec_ext = 2'b11;
                end else begin
                    dec_alu = {1'b0, in_inst};
                    dec_ext = 2'b01;
                end
            end
            2'b10: begin
                dec_vf = in_flag_v;
                if (!in_inst[0]) begin
                    dec_rmem = 1'b1;
                    dec_wreg = 1'b1;
                    dec_ext  = 2'b01;
                end else begin
                    dec_wmem = 1'b1;
                    dec_alu  = 3'b101;
                end
            end
            default: begin
                case (in_inst)
                    2'b00: begin
                        dec_jmp  = 2'b01;
                        dec_jsel = 1'b1;
                        dec_ext  = 2'b10;
                    end
                    2'b01: begin
                        dec_jmp  = 2'b01;
                        dec_jsel = 1'b1;
                        dec_ext  = 2'b10;
                        dec_wreg = 1'b1;
                    end
                    2'b10: begin
                        dec_jmp     = 2'b10;
                        dec_cond_en = 1'b1;
                        dec_jsel    = 1'b1;
                        dec_ext     = 2'b10;
                    end
                    default: begin
                        dec_jmp = 2'b11;
                        dec_alu = 3'b101;
                    end
                endcase
            end
        endcase
        dec_mux_r = {dec_vf, dec_vf};
    end

    always_comb begin
        case (dec_ext)
            2'b01:   ext_val = {{5{in_imm[26]}}, in_imm};
            2'b10:   ext_val = {5'b0, in_imm};
            2'b11:   ext_val = {in_imm[15:0], 16'h0000};
            default: ext_val = '0;
        endcase
    end

    always_comb begin
        scal_d = scal_q;
        vec_d  = vec_q;
        if (wb_en) begin
            if (wb_vec) vec_d[wb_addr] = wb_data;
            else        scal_d[wb_addr] = wb_data[LANE_W-1:0];
        end
    end

    always_comb begin
        rs1_s = scal_q[in_rs1];
        rs2_s = scal_q[in_rs2];
        rs1_v = vec_q[in_rs1];
        rs2_v = vec_q[in_rs2];
`ifdef DECODE_WB_BYPASS_EN
        if (wb_en && !wb_vec && wb_addr == in_rs1) rs1_s = wb_data[LANE_W-1:0];
        if (wb_en && !wb_vec && wb_addr == in_rs2) rs2_s = wb_data[LANE_W-1:0];
        if (wb_en &&  wb_vec && wb_addr == in_rs1) rs1_v = wb_data;
        if (wb_en &&  wb_vec && wb_addr == in_rs2) rs2_v = wb_data;
`endif
    end

    assign op_a = dec_jsel ? VW'(in_pc) : (dec_mux_r[1] ? rs1_v : VW'(rs1_s));
    assign op_b = (dec_ext != 2'b00) ? VW'(ext_val) : (dec_mux_r[0] ? rs2_v : VW'(rs2_s));

    // A source is only a real dependency when its register value actually feeds an operand.
    assign rs1_used = !dec_jsel;
    assign rs2_used = (dec_ext == 2'b00);
    assign load_use = out_valid_q && r_q.rmem && r_q.wreg && (r_q.vf == dec_vf) &&
                      ((rs1_used && r_q.rd == in_rs1) || (rs2_used && r_q.rd == in_rs2));
`ifdef DECODE_WB_BYPASS_EN
    assign wb_hazard = 1'b0;
`else
    assign wb_hazard = wb_en && (wb_vec == dec_vf) &&
                       ((rs1_used && wb_addr == in_rs1) || (rs2_used && wb_addr == in_rs2));
`endif
    assign hazard   = load_use || wb_hazard;
    assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        r_new.a       = op_a;
        r_new.b       = op_b;
        r_new.rd      = in_rd;
        r_new.rs1     = dec_ext[1] ? '0 : in_rs1;
        r_new.rs2     = (dec_ext != 2'b00) ? '0 : in_rs2;
        r_new.vf      = dec_vf;
        r_new.wmem    = dec_wmem;
        r_new.rmem    = dec_rmem;
        r_new.wreg    = dec_wreg;
        r_new.cond_en = dec_cond_en;
        r_new.jmp     = dec_jmp;
        r_new.alu     = dec_alu;
    end

    always_comb begin
        r_d         = r_q;
        out_valid_d = out_valid_q;
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            out_valid_d = accept;
            if (accept) r_d = r_new;
        end
        if (in_valid && !in_ready && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scal_q      <= '{default: '0};
            vec_q       <= '{default: '0};
            r_q         <= '0;
            out_valid_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            scal_q      <= scal_d;
            vec_q       <= vec_d;
            r_q         <= r_d;
            out_valid_q <= out_valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_a       = r_q.a;
    assign out_b       = r_q.b;
    assign out_rd      = r_q.rd;
    assign out_rs1     = r_q.rs1;
    assign out_rs2     = r_q.rs2;
    assign out_vf      = r_q.vf;
    assign out_wmem    = r_q.wmem;
    assign out_rmem    = r_q.rmem;
    assign out_wreg    = r_q.wreg;
    assign out_cond_en = r_q.cond_en;
    assign out_jmp     = r_q.jmp;
    assign out_alu     = r_q.alu;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_vector_decode_stage.sv
// Self-checking bench for vector_decode_stage: directed scenarios plus randomized traffic against a reference model.
module tb_vector_decode_stage;

    localparam int LANES  = 4;
    localparam int LANE_W = 32;
    localparam int NREGS  = 16;
    localparam int VW     = LANES * LANE_W;
    localparam int AW     = 4;
    localparam int OW     = 2 * VW + 3 * AW + 10;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_ready, in_flag_v;
    logic [1:0] in_op, in_inst;
    logic [26:0] in_imm;
    logic [31:0] in_pc;
    logic [AW-1:0] in_rd, in_rs1, in_rs2;
    logic wb_en, wb_vec;
    logic [AW-1:0] wb_addr;
    logic [VW-1:0] wb_data;
    logic flush, out_valid, out_ready;
    logic [VW-1:0] out_a, out_b;
    logic [AW-1:0] out_rd, out_rs1, out_rs2;
    logic out_vf, out_wmem, out_rmem, out_wreg, out_cond_en;
    logic [1:0] out_jmp;
    logic [2:0] out_alu;
    logic [15:0] stall_cnt;
    logic [OW-1:0] act_out;

    int checks = 0;
    int errors = 0;

    vector_decode_stage #(.LANES(LANES), .LANE_W(LANE_W), .NREGS(NREGS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_inst(in_inst), .in_flag_v(in_flag_v), .in_imm(in_imm), .in_pc(in_pc),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .wb_en(wb_en), .wb_vec(wb_vec), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_vf(out_vf), .out_wmem(out_wmem), .out_rmem(out_rmem), .out_wreg(out_wreg),
        .out_cond_en(out_cond_en), .out_jmp(out_jmp), .out_alu(out_alu), .stall_cnt(stall_cnt)
    );

    assign act_out = {out_a, out_b, out_rd, out_rs1, out_rs2, out_vf, out_wmem, out_rmem,
                      out_wreg, out_cond_en, out_jmp, out_alu};

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       vf, wmem, rmem, wreg, cond_en;
        logic [1:0] jmp;
        logic [2:0] alu;
        logic       pc_a;      // operand A is the PC
        logic [1:0] imm_kind;  // 0 none, 1 signed imm, 2 unsigned imm, 3 upper-half imm
    } ctl_t;

    logic [LANE_W-1:0] m_sreg [NREGS];
    logic [VW-1:0]     m_vreg [NREGS];
    logic              m_valid, m_load, m_vf;
    logic [AW-1:0]     m_rd;
    logic [OW-1:0]     m_out;
    logic [15:0]       m_stall;
    logic              exp_ready, exp_new_load, exp_new_vf;
    logic [OW-1:0]     exp_new;
    logic [OW-1:0]     exp_q [$];

    // Instruction set by mnemonic: add/sub/and/or (reg), addi.. / lui, ld / st, j / jal / beq / jr.
    function automatic ctl_t ref_ctl(input logic [1:0] op, input logic [1:0] inst, input logic fv);
        ctl_t c;
        c = '0;
        if (op == 2'd0) begin
            c.vf = fv; c.wreg = 1'b1; c.alu = 3'(inst);
        end else if (op == 2'd1) begin
            c.vf = fv; c.wreg = 1'b1;
            if (inst == 2'd3) begin c.alu = 3'd4; c.imm_kind = 2'd3; end
            else begin c.alu = 3'(inst); c.imm_kind = 2'd1; end
        end else if (op == 2'd2) begin
            c.vf = fv;
            if (inst == 2'd0 || inst == 2'd2) begin c.rmem = 1'b1; c.wreg = 1'b1; c.imm_kind = 2'd1; end
            else begin c.wmem = 1'b1; c.alu = 3'd5; end
        end else begin
            if (inst == 2'd3) begin c.jmp = 2'd3; c.alu = 3'd5; end
            else begin
                c.pc_a = 1'b1; c.imm_kind = 2'd2;
                c.jmp = (inst == 2'd2) ? 2'd2 : 2'd1;
                c.cond_en = (inst == 2'd2);
                c.wreg = (inst == 2'd1);
            end
        end
        return c;
    endfunction

    function automatic logic [VW-1:0] ref_src(input logic vf, input logic [AW-1:0] a);
        logic [VW-1:0] v;
        v = vf ? m_vreg[a] : VW'(m_sreg[a]);
`ifdef DECODE_WB_BYPASS_EN
        if (wb_en && wb_vec == vf && wb_addr == a) v = vf ? wb_data : VW'(wb_data[LANE_W-1:0]);
`endif
        return v;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_load = 1'b0; m_vf = 1'b0; m_rd = '0; m_out = '0; m_stall = '0;
        for (int i = 0; i < NREGS; i++) begin
            m_sreg[i] = '0;
            m_vreg[i] = '0;
        end
    endtask

    // Expected in_ready and the payload this cycle's instruction would produce.
    task automatic predict();
        ctl_t c;
        logic u1, u2, lu, wbh;
        logic [31:0] immv;
        logic [VW-1:0] a, b;
        c = ref_ctl(in_op, in_inst, in_flag_v);
        u1 = !c.pc_a;
        u2 = (c.imm_kind == 2'd0);
        lu = m_valid && m_load && (m_vf == c.vf) &&
             ((u1 && m_rd == in_rs1) || (u2 && m_rd == in_rs2));
`ifdef DECODE_WB_BYPASS_EN
        wbh = 1'b0;
`else
        wbh = wb_en && (wb_vec == c.vf) && ((u1 && wb_addr == in_rs1) || (u2 && wb_addr == in_rs2));
`endif
        exp_ready = (!m_valid || out_ready) && !lu && !wbh && !flush;
        case (c.imm_kind)
            2'd1:    immv = 32'(int'($signed(in_imm)));
            2'd2:    immv = 32'(in_imm);
            2'd3:    immv = (32'(in_imm) % 32'd65536) * 32'd65536;
            default: immv = 32'd0;
        endcase
        a = c.pc_a ? VW'(in_pc) : ref_src(c.vf, in_rs1);
        b = (c.imm_kind != 2'd0) ? VW'(immv) : ref_src(c.vf, in_rs2);
        exp_new = {a, b, in_rd, (c.imm_kind >= 2'd2) ? AW'(0) : in_rs1,
                   (c.imm_kind != 2'd0) ? AW'(0) : in_rs2,
                   c.vf, c.wmem, c.rmem, c.wreg, c.cond_en, c.jmp, c.alu};
        exp_new_load = c.rmem && c.wreg;
        exp_new_vf   = c.vf;
    endtask

    // Advance one clock and update the model; returns 1 time unit after the edge.
    task automatic tick();
        logic acc, we, wv;
        logic [AW-1:0] wa;
        logic [VW-1:0] wd;
        acc = in_valid && exp_ready;
        we = wb_en; wv = wb_vec; wa = wb_addr; wd = wb_data;
        if (in_valid && !exp_ready && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
        @(posedge clk);
        if (flush) m_valid = 1'b0;
        else if (!m_valid || out_ready) begin
            m_valid = acc;
            if (acc) begin
                m_out = exp_new; m_load = exp_new_load; m_vf = exp_new_vf; m_rd = in_rd;
                exp_q.push_back(exp_new);
            end
        end
        if (we) begin
            if (wv) m_vreg[wa] = wd;
            else    m_sreg[wa] = wd[LANE_W-1:0];
        end
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        in_valid = 1'b0; in_op = '0; in_inst = '0; in_flag_v = 1'b0; in_imm = '0; in_pc = '0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        wb_en = 1'b0; wb_vec = 1'b0; wb_addr = '0; wb_data = '0;
        flush = 1'b0; out_ready = 1'b1;
    endtask

    task automatic drive_inst(input logic [1:0] op, input logic [1:0] inst, input logic fv,
                              input logic [AW-1:0] rd, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
        in_valid = 1'b1; in_op = op; in_inst = inst; in_flag_v = fv;
        in_imm = 27'($urandom); in_pc = $urandom;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++;
        if (act_out !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", act_out); end
        checks++;
        if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", stall_cnt); end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_vector_read();
        logic [VW-1:0] v3;
        v3 = {32'h4, 32'h3, 32'h2, 32'h1};
        wb_en = 1'b1; wb_vec = 1'b1; wb_addr = 4'd3; wb_data = v3;
        predict(); tick();
        wb_en = 1'b0;
        drive_inst(2'd0, 2'd0, 1'b1, 4'd1, 4'd3, 4'd0);
        predict(); #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL vec_read_ready: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL vec_read_valid: got %b expected 1", out_valid); end
        checks++;
        if (out_a !== v3) begin errors++; $display("FAIL vec_read_a: got %h expected %h", out_a, v3); end
        checks++;
        if (act_out !== m_out) begin errors++; $display("FAIL vec_read_fields: got %h expected %h", act_out, m_out); end
        predict(); tick();
    endtask

    task automatic test_backpressure();
        logic [OW-1:0] snap;
        logic [15:0] s0;
        drive_inst(2'd1, 2'd1, 1'b0, 4'd2, 4'd9, 4'd10);
        predict(); tick();
        in_valid = 1'b0; out_ready = 1'b0;
        snap = m_out; s0 = m_stall;
        for (int i = 0; i < 3; i++) begin
            predict(); #1;
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
            tick();
            checks++;
            if (out_valid !== 1'b1 || act_out !== snap)
                begin errors++; $display("FAIL bp_hold[%0d]: got %b/%h expected 1/%h", i, out_valid, act_out, snap); end
            checks++;
            if (stall_cnt !== s0) begin errors++; $display("FAIL bp_stall[%0d]: got %0d expected %0d", i, stall_cnt, s0); end
        end
        out_ready = 1'b1;
        predict(); tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_load_use();
        logic [15:0] s0;
        drive_inst(2'd2, 2'd0, 1'b0, 4'd5, 4'd2, 4'd0);
        predict(); tick();
        drive_inst(2'd0, 2'd1, 1'b0, 4'd6, 4'd1, 4'd5);
        predict(); #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_ready_low: got %b expected 0", in_ready); end
        s0 = stall_cnt;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble: got %b expected 0", out_valid); end
        checks++;
        if (stall_cnt !== s0 + 16'd1) begin errors++; $display("FAIL lu_stall: got %0d expected %0d", stall_cnt, s0 + 16'd1); end
        predict(); #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_ready_retry: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_rs2 !== 4'd5)
            begin errors++; $display("FAIL lu_issue: got %b/%0d expected 1/5", out_valid, out_rs2); end
        checks++;
        if (act_out !== m_out) begin errors++; $display("FAIL lu_fields: got %h expected %h", act_out, m_out); end
        predict(); tick();
    endtask

    task automatic test_wb_same_cycle();
        wb_en = 1'b1; wb_vec = 1'b0; wb_addr = 4'd7; wb_data = VW'(8'hA5);
        drive_inst(2'd0, 2'd0, 1'b0, 4'd2, 4'd7, 4'd0);
        predict(); #1;
`ifdef DECODE_WB_BYPASS_EN
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL wb_bypass_ready: got %b expected 1", in_ready); end
        tick();
        wb_en = 1'b0;
`else
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL wb_conflict_ready: got %b expected 0", in_ready); end
        tick();
        wb_en = 1'b0;
        predict(); #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL wb_retry_ready: got %b expected 1", in_ready); end
        tick();
`endif
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_a !== VW'(8'hA5))
            begin errors++; $display("FAIL wb_out_a: got %b/%h expected 1/a5", out_valid, out_a); end
        predict(); tick();
    endtask

    task automatic test_flush();
        drive_inst(2'd3, 2'd1, 1'b0, 4'd8, 4'd4, 4'd4);
        predict(); tick();
        checks++;
        if (act_out !== m_out) begin errors++; $display("FAIL flush_pre_fields: got %h expected %h", act_out, m_out); end
        drive_inst(2'd0, 2'd2, 1'b0, 4'd9, 4'd1, 4'd2);
        out_ready = 1'b0; flush = 1'b1;
        predict(); #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
        checks++;
        if (stall_cnt !== m_stall) begin errors++; $display("FAIL flush_stall: got %0d expected %0d", stall_cnt, m_stall); end
    endtask

    task automatic test_random();
        logic pending;
        logic [OW-1:0] e;
        pending = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 80; i++) begin
            if (!pending) begin
                drive_inst(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                           AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)));
                in_valid = ($urandom_range(0, 4) != 0);
            end
            wb_en = ($urandom_range(0, 2) == 0);
            wb_vec = 1'($urandom_range(0, 1));
            wb_addr = AW'($urandom_range(0, 3));
            wb_data = {$urandom, $urandom, $urandom, $urandom};
            predict(); #1;
            checks++;
            if (in_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d]: got %b expected %b", i, in_ready, exp_ready); end
            pending = in_valid && !exp_ready;
            tick();
            checks++;
            if (out_valid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, out_valid, m_valid); end
            if (m_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (act_out !== e) begin errors++; $display("FAIL rnd_fields[%0d]: got %h expected %h", i, act_out, e); end
            end
            checks++;
            if (stall_cnt !== m_stall) begin errors++; $display("FAIL rnd_stall[%0d]: got %0d expected %0d", i, stall_cnt, m_stall); end
        end
        set_idle();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_leftover: got %0d expected 0", exp_q.size()); end
        predict(); tick();
    endtask

    task automatic test_reset_mid_stall();
        drive_inst(2'd0, 2'd0, 1'b1, 4'd1, 4'd3, 4'd3);
        predict(); tick();
        drive_inst(2'd0, 2'd3, 1'b0, 4'd2, 4'd5, 4'd6);
        out_ready = 1'b0;
        predict(); tick();
        predict(); tick();
        checks++;
        if (stall_cnt !== m_stall) begin errors++; $display("FAIL mid_stall_cnt: got %0d expected %0d", stall_cnt, m_stall); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || act_out !== '0)
            begin errors++; $display("FAIL async_reset_out: got %b/%h expected 0/0", out_valid, act_out); end
        checks++;
        if (stall_cnt !== 16'd0) begin errors++; $display("FAIL async_reset_stall: got %0d expected 0", stall_cnt); end
        set_idle();
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        drive_inst(2'd0, 2'd0, 1'b1, 4'd1, 4'd3, 4'd3);
        predict(); tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_a !== '0)
            begin errors++; $display("FAIL rf_cleared: got %b/%h expected 1/0", out_valid, out_a); end
    endtask

    initial begin
        test_reset();
        test_vector_read();
        test_backpressure();
        test_load_use();
        test_wb_same_cycle();
        test_flush();
        test_random();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
